// File: rtl/lcd_seq_ctrl.sv
// LCD command/data sequencer.
// Walks a bank of table entries from index `count` down to 0. For each entry it
// issues a one-cycle write request, waits (bounded) for the write engine to
// finish, optionally settles for POST_DLY cycles, then moves on to the next
// entry. An abort or a write timeout ends the sequence and raises the sticky
// error flag.
module lcd_seq_ctrl #(
  parameter int IDX_W    = 5,
  parameter int POST_DLY = 50,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [IDX_W-1:0] count,
  input  logic             abort,
  input  logic             wr_finish,
  output logic             wr_enable,
  output logic [IDX_W-1:0] idx,
  output logic             sel_init,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Counters hold values up to their parameter, so they never need to wrap.
  localparam int TO_W  = $clog2(TIMEOUT) + 1;
  localparam int DLY_W = $clog2(POST_DLY) + 1;

  // Counters count down to zero; zero marks the last cycle of the phase.
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'((POST_DLY > 0) ? (POST_DLY - 1) : 0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WAIT  = 3'd2,
    DELAY = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [DLY_W-1:0] dly_cnt;

  // Sequencer FSM; wr_enable, busy and done are registered alongside the state
  // so that each one always reflects the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_enable <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      idx       <= '0;
      sel_init  <= 1'b0;
      to_cnt    <= '0;
      dly_cnt   <= '0;
    end else begin
      wr_enable <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WRITE;
            idx       <= count;
            sel_init  <= mode;
            error     <= 1'b0;
            wr_enable <= 1'b1;
            busy      <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          // Abort outranks every other transition in the active states.
          if (abort) begin
            state <= IDLE;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            case (state)
              WRITE: begin
                to_cnt <= TO_LOAD;
                state  <= WAIT;
              end

              WAIT: begin
                // A finish on the last allowed cycle still counts as success.
                if (wr_finish) begin
                  if (POST_DLY == 0) begin
                    state <= NEXT;
                  end else begin
                    dly_cnt <= DLY_LOAD;
                    state   <= DELAY;
                  end
                end else if (to_cnt == '0) begin
                  state <= DONE;
                  error <= 1'b1;
                  done  <= 1'b1;
                end else begin
                  to_cnt <= to_cnt - 1'b1;
                end
              end

              DELAY: begin
                if (dly_cnt == '0) begin
                  state <= NEXT;
                end else begin
                  dly_cnt <= dly_cnt - 1'b1;
                end
              end

              NEXT: begin
                // Index 0 is the final entry; idx is never decremented past it.
                if (idx == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  idx       <= idx - 1'b1;
                  state     <= WRITE;
                  wr_enable <= 1'b1;
                end
              end

              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Testbench for lcd_seq_ctrl with POST_DLY=2 and TIMEOUT=4.
module tb_lcd_seq_ctrl;

  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [IDX_W-1:0] count = '0;
  logic             abort = 1'b0;
  logic             wr_finish = 1'b0;
  logic             wr_enable;
  logic [IDX_W-1:0] idx;
  logic             sel_init;
  logic             busy;
  logic             done;
  logic             error;

  int tests = 0;
  int failed = 0;
  int dc, fw, nw;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             sel;
  } wr_exp_t;

  typedef struct {
    logic err;
    logic sel;
  } done_exp_t;

  wr_exp_t   exp_wr[$];
  done_exp_t exp_done[$];

  lcd_seq_ctrl #(.IDX_W(IDX_W), .POST_DLY(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
    .abort(abort), .wr_finish(wr_finish), .wr_enable(wr_enable), .idx(idx),
    .sel_init(sel_init), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic push_wr(input logic [IDX_W-1:0] i, input logic s);
    wr_exp_t e;
    e.idx = i; e.sel = s;
    exp_wr.push_back(e);
  endtask

  task automatic push_done(input logic er, input logic s);
    done_exp_t e;
    e.err = er; e.sel = s;
    exp_done.push_back(e);
  endtask

  // Advance one clock and compare any write/done pulse against the scoreboard.
  task automatic tick();
    wr_exp_t   we;
    done_exp_t de;
    @(posedge clk);
    #1;
    if (wr_enable === 1'b1) begin
      tests++;
      if (exp_wr.size() == 0) begin
        failed++;
        $display("FAIL wr_unexpected: got wr_enable with idx=%0d, required no write", idx);
      end else begin
        we = exp_wr.pop_front();
        if (idx !== we.idx || sel_init !== we.sel) begin
          failed++;
          $display("FAIL wr_entry: got idx=%0d sel=%0b, required idx=%0d sel=%0b",
                   idx, sel_init, we.idx, we.sel);
        end
      end
    end
    if (done === 1'b1) begin
      tests++;
      if (exp_done.size() == 0) begin
        failed++;
        $display("FAIL done_unexpected: got done with error=%0b, required no done", error);
      end else begin
        de = exp_done.pop_front();
        if (error !== de.err || sel_init !== de.sel) begin
          failed++;
          $display("FAIL done_state: got error=%0b sel=%0b, required error=%0b sel=%0b",
                   error, sel_init, de.err, de.sel);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_wr.size() != 0 || exp_done.size() != 0) begin
      failed++;
      $display("FAIL %s_drain: got %0d writes and %0d dones outstanding, required 0 and 0",
               name, exp_wr.size(), exp_done.size());
    end
    exp_wr.delete();
    exp_done.delete();
  endtask

  // Start a sequence and answer each write with wr_finish on the k-th WAIT
  // cycle (k=0: never). Cycle 1 is the first cycle after the start edge.
  task automatic run_seq(input logic [IDX_W-1:0] c, input logic m, input int k,
                         output int done_cyc, output int first_wr, output int n_wr);
    int cyc;
    int wcnt;
    bit got;
    count = c; mode = m; start = 1'b1;
    cyc = 0; wcnt = -1; got = 0;
    done_cyc = -1; first_wr = -1; n_wr = 0;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      start = 1'b0;
      wr_finish = 1'b0;
      if (wr_enable === 1'b1) begin
        n_wr++;
        if (first_wr < 0) first_wr = cyc;
        wcnt = 0;
      end else if (wcnt >= 0) begin
        wcnt++;
        if (wcnt == k) begin
          wr_finish = 1'b1;
          wcnt = -1;
        end
      end
      if (done === 1'b1) begin
        got = 1;
        done_cyc = cyc;
      end
    end
    wr_finish = 1'b0;
    if (!got) begin
      tests++;
      failed++;
      $display("FAIL seq_no_done: got no done within %0d cycles, required a done pulse", cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests++;
    if (got !== req) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if ({wr_enable, busy, done, error, sel_init} !== 5'b0 || idx !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got wr=%0b busy=%0b done=%0b err=%0b sel=%0b idx=%0d, required all 0",
               wr_enable, busy, done, error, sel_init, idx);
    end
  endtask

  task automatic test_basic();
    rst = 1'b1;
    push_wr(5'd0, 1'b1);
    push_done(1'b0, 1'b1);
    run_seq(5'd0, 1'b1, 3, dc, fw, nw);
    check_int("basic_first_wr_cycle", fw, 1);
    check_int("basic_done_cycle", dc, 8);
    check_int("basic_wr_count", nw, 1);
    tick();
    tests++;
    if (busy !== 1'b0 || sel_init !== 1'b1 || idx !== 5'd0 || error !== 1'b0) begin
      failed++;
      $display("FAIL basic_idle: got busy=%0b sel=%0b idx=%0d err=%0b, required busy=0 sel=1 idx=0 err=0",
               busy, sel_init, idx, error);
    end
    check_drained("basic");
  endtask

  task automatic test_multi();
    for (int i = 3; i >= 0; i--) push_wr(IDX_W'(i), 1'b0);
    push_done(1'b0, 1'b0);
    run_seq(5'd3, 1'b0, 1, dc, fw, nw);
    check_int("multi_done_cycle", dc, 21);
    check_int("multi_wr_count", nw, 4);
    tick();
    check_drained("multi");
  endtask

  task automatic test_timeout();
    push_wr(5'd1, 1'b1);
    push_done(1'b1, 1'b1);
    run_seq(5'd1, 1'b1, 0, dc, fw, nw);
    check_int("timeout_done_cycle", dc, 6);
    tick();
    tests++;
    if (error !== 1'b1 || busy !== 1'b0 || idx !== 5'd1) begin
      failed++;
      $display("FAIL timeout_sticky: got err=%0b busy=%0b idx=%0d, required err=1 busy=0 idx=1",
               error, busy, idx);
    end
    check_drained("timeout");
  endtask

  task automatic test_error_clear();
    push_wr(5'd0, 1'b0);
    push_done(1'b0, 1'b0);
    run_seq(5'd0, 1'b0, 1, dc, fw, nw);
    check_int("clear_done_cycle", dc, 6);
    tick();
    check_drained("clear");
  endtask

  task automatic test_tiebreak();
    push_wr(5'd0, 1'b1);
    push_done(1'b0, 1'b1);
    run_seq(5'd0, 1'b1, 4, dc, fw, nw);
    check_int("tiebreak_done_cycle", dc, 9);
    tick();
    tests++;
    if (error !== 1'b0) begin
      failed++;
      $display("FAIL tiebreak_error: got err=%0b, required 0", error);
    end
    check_drained("tiebreak");
  endtask

  task automatic test_abort();
    int wcnt;
    push_wr(5'd3, 1'b0);
    push_wr(5'd2, 1'b0);
    count = 5'd3; mode = 1'b0; start = 1'b1;
    wcnt = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      start = 1'b0; wr_finish = 1'b0; abort = 1'b0;
      if (wr_enable === 1'b1) begin
        wcnt = 0;
      end else if (wcnt >= 0) begin
        wr_finish = 1'b1;
        wcnt = -1;
      end
      // Restart attempts with a different count while busy.
      if (cyc >= 2 && cyc <= 4) begin
        start = 1'b1;
        count = 5'd7;
      end
      // Stray finishes during DELAY and IDLE.
      if (cyc == 3 || cyc == 4 || cyc == 11) wr_finish = 1'b1;
      if (cyc == 8 || cyc == 9 || cyc == 10) abort = 1'b1;
      if (cyc == 9 || cyc == 12) begin
        tests++;
        if (busy !== 1'b0 || error !== 1'b1) begin
          failed++;
          $display("FAIL abort_idle_c%0d: got busy=%0b err=%0b, required busy=0 err=1",
                   cyc, busy, error);
        end
      end
    end
    abort = 1'b0; start = 1'b0; wr_finish = 1'b0;
    check_drained("abort");
  endtask

  task automatic test_reset_mid();
    push_wr(5'd2, 1'b1);
    count = 5'd2; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({wr_enable, busy, done, error, sel_init} !== 5'b0 || idx !== '0) begin
      failed++;
      $display("FAIL reset_mid: got wr=%0b busy=%0b done=%0b err=%0b sel=%0b idx=%0d, required all 0",
               wr_enable, busy, done, error, sel_init, idx);
    end
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_finish = (i == 1);
      tick();
    end
    wr_finish = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_idle: got busy=%0b, required 0", busy);
    end
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi();
    test_timeout();
    test_error_clear();
    test_tiebreak();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
